// File: rtl/integrador.sv
// -----------------------------------------------------------------------------
// integrador -- sequential fixed-point integrator
//
// Computes y <= y + (K*x) >>> F for every accepted sample. The product is
// formed by a serial shift-add multiplier over W cycles on sign/magnitude
// operands, so the datapath needs no hardware multiplier.
//
// Parameters
//   W  sample / accumulator width (two's complement)
//   F  fractional bits of K; the product is shifted right arithmetically by F
//   K  signed gain in Q(W-F).F (default 1.0)
//
// Ports
//   CLK     in   rising-edge clock
//   Reset   in   asynchronous active-low reset
//   Clear   in   synchronous clear: y<=0, abort any operation
//   Enable  in   sample strobe, accepted only while Ready=1
//   x       in   signed input sample (W bits)
//   Ready   out  high in IDLE; a sample can be accepted
//   Valid   out  one-cycle pulse, y was updated on this edge
//   y       out  signed accumulator value (registered)
//
// Configuration macro
//   INTEGRADOR_SAT_EN  defined: the sum is clamped to the W-bit signed range
//                      (anti-windup); undefined: two's-complement wrap-around.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module integrador #(
    parameter int                  W = 12,
    parameter int                  F = 8,
    parameter logic signed [W-1:0] K = 12'sd256
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         Enable,
    input  logic [W-1:0] x,
    output logic         Ready,
    output logic         Valid,
    output logic [W-1:0] y
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int PW = 2 * W - F;   // width of the shifted product
    localparam int SW = PW + 1;      // width of the accumulation sum

    localparam logic [CW-1:0] LAST  = CW'(W - 1);
    localparam logic [W-1:0]  K_MAG = K[W-1] ? (~K + W'(1)) : K;
    localparam logic [W-1:0]  Y_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  Y_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  mcand_q, mcand_d;    // |x|, shifted left every MUL cycle
    logic [W-1:0]    mplier_q, mplier_d;  // |K|, shifted right every MUL cycle
    logic [2*W-1:0]  prod_q, prod_d;
    logic            sign_q, sign_d;
    logic [W-1:0]    y_q, y_d;
    logic            valid_q, valid_d;

    logic [W-1:0]    x_mag;
    logic [2*W-1:0]  prod_signed;
    logic [PW-1:0]   p;
    logic [SW-1:0]   s;
    logic [W-1:0]    y_sel;
    logic            unused_bits;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            sign_q   <= 1'b0;
            y_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (Enable) state_d = MUL;
                MUL:     if (cnt_q == LAST) state_d = ACC;
                ACC:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // The most negative input maps to magnitude 2^(W-1), which still fits the
    // W-bit unsigned magnitude.
    assign x_mag = x[W-1] ? (~x + W'(1)) : x;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        y_d      = y_q;
        valid_d  = 1'b0;

        prod_signed = sign_q ? (~prod_q + (2*W)'(1)) : prod_q;
        // Dropping the low F bits of a two's-complement value floors toward -inf.
        p = prod_signed[2*W-1:F];
        s = {p[PW-1], p} + {{(SW-W){y_q[W-1]}}, y_q};

`ifdef INTEGRADOR_SAT_EN
        // The sum fits in W bits when all bits above bit W-1 match the sign.
        if (s[SW-1:W-1] == {(SW-W+1){s[SW-1]}}) y_sel = s[W-1:0];
        else                                    y_sel = s[SW-1] ? Y_MIN : Y_MAX;
`else
        y_sel = s[W-1:0];
`endif

        if (Clear) begin
            cnt_d = '0;
            y_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Enable) begin
                        mcand_d  = {{W{1'b0}}, x_mag};
                        mplier_d = K_MAG;
                        prod_d   = '0;
                        sign_d   = x[W-1] ^ K[W-1];
                        cnt_d    = '0;
                    end
                end
                MUL: begin
                    if (mplier_q[0]) prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                end
                ACC: begin
                    y_d     = y_sel;
                    valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef INTEGRADOR_SAT_EN
    assign unused_bits = ^prod_signed[F-1:0];
`else
    assign unused_bits = ^{prod_signed[F-1:0], s[SW-1:W]};
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        Ready = (state_q == IDLE);
        Valid = valid_q;
        y     = y_q;
    end

endmodule

// File: doc/integrador.md
# integrador

Sequential fixed-point integrator: the inverse of the team's differentiator. It accepts a signed difference sample `x` and computes `y <= y + (K*x) >>> F`. The multiply is a serial shift-add over `W` cycles, so one multiplier-free datapath serves the whole signal chain. It sits downstream of the differentiator / ADC sample path and reconstructs the level signal from the derivative stream.

## Interface
- `W`, 12: sample / accumulator width, two's complement.
- `F`, 8: fractional bits of `K`; the product is arithmetically shifted right by `F`.
- `K`, 12'sd256: signed gain in Q(W-F).F; the default is unity.
- `CLK`  in  1  single clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Clear`  in  1  synchronous; zeroes the accumulator and aborts any operation.
- `Enable`  in  1  sample strobe; accepted only when `Ready`=1.
- `x`  in  W  signed input sample; captured on accept.
- `Ready`  out  1  high in IDLE; block can accept a sample.
- `Valid`  out  1  one-cycle pulse; `y` was updated on this edge.
- `y`  out  W  signed accumulator value; registered.

## Operation
- States:
  - IDLE (`Ready`=1).
  - MUL: `W` cycles; iteration counter runs 0..W-1.
  - ACC: 1 cycle.
- IDLE -> MUL on `Enable`&&`Ready`:
  - capture `x` into the operand register;
  - record sign = sign(x) XOR sign(K);
  - load magnitudes |x| and |K|, each W bits unsigned;
  - clear the 2W-bit partial product.
- MUL: each cycle, if the multiplier LSB is 1, add the shifted multiplicand; shift. Leave after iteration W-1.
- ACC:
  - apply the sign to the product;
  - `p = product >>> F` (floor toward -inf), width 2W-F;
  - `s = y + p` computed in 2W-F+1 bits;
  - write `y` (see Configuration); pulse `Valid`; return to IDLE.
- `Enable` while `Ready`=0 is ignored. No queueing; the sample is lost.
- `Clear` (any state): `y`<=0, FSM<=IDLE, `Valid`<=0. In-flight sample discarded.
- `Clear` and `Enable` in the same cycle: `Clear` wins; the sample is not accepted.
- |x| = 2^(W-1) (most negative input) must multiply correctly. Magnitude registers are W bits unsigned.
- Reset asserted mid-operation: all state returns to reset values immediately; no `Valid`.

## Timing
- Reset values: `y`=0, `Valid`=0, `Ready`=1, FSM=IDLE, counters 0.
- Accept edge = E. `Ready`=0 from E.
- `y` and `Valid` update on edge E+W+1, where `Valid` is high for exactly one cycle.
- `Ready`=1 again from edge E+W+1. The earliest next accept is edge E+W+2.
- Throughput: one sample per W+2 cycles, i.e. 14 cycles at the default.
- `y` holds its value between updates; `Valid`=0 at all other times.

## Configuration
- `INTEGRADOR_SAT_EN` defined: `s` is clamped to [-2^(W-1), 2^(W-1)-1] before writing `y` (anti-windup).
- Not defined: `y` = low W bits of `s`, i.e. two's-complement wrap-around.

## Test plan
- Reset: drive `Reset`=0 mid-MUL, then release -> `y`=0, `Ready`=1, `Valid`=0, and no `Valid` pulse follows.
- Unity gain, default parameters: send x=100, 100, 100, then -50 -> `y`=100, 200, 300, 250. Each `Valid` occurs 13 edges after its accept edge; `Ready` is low in between.
- Truncation, K=128 (0.5): from `y`=0, send x=-3 -> `y`=-2 (floor of -1.5). Then send x=3 -> `y`=-1.
- Overflow: send x=2000 twice.
  - With `INTEGRADOR_SAT_EN`: `y`=2000, then 2047.
  - Without: `y`=2000, then -96.
  - Also send x=-2048 with K=256 from 0 -> `y`=-2048.
- Busy / Clear:
  - pulse `Enable` with x=500 during MUL of x=10 -> single `Valid`, `y`=10;
  - assert `Clear` together with `Enable` -> `y`=0 and no accept;
  - assert `Clear` mid-MUL -> `y`=0, `Ready`=1 on the next cycle, no `Valid`.
